// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: default geometry and Gray/binary pointer conversions
// used by both the read-side and write-side pointer controllers.
package async_fifo_pkg;

    localparam int unsigned default_fifo_width = 8;
    localparam int unsigned default_addr_size  = $clog2(default_fifo_width);

    // Conversions operate on a zero-extended 32-bit value; callers cast to pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter for an addr_size+1 bit FIFO pointer.
module gray_to_bin
    import async_fifo_pkg::*;
#(
    parameter int unsigned addr_size = default_addr_size
) (
    input  logic [addr_size:0] gray,
    output logic [addr_size:0] bin
);

    localparam int unsigned ptr_w = addr_size + 1;

    assign bin = ptr_w'(gray2bin(32'(gray)));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer controller of an async FIFO: owns the read pointer, produces the
// Gray pointer for the write domain, and derives empty/occupancy from the synced write pointer.
module fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int unsigned fifo_width = default_fifo_width,
    parameter int unsigned addr_size  = $clog2(fifo_width)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_inc,
    input  logic [addr_size:0]   sync_wptr,
    output logic [addr_size-1:0] rd_addr,
    output logic [addr_size:0]   rd_ptr,
    output logic                 empty,
    output logic [addr_size:0]   rd_count,
    output logic                 rd_ack
);

    localparam int unsigned ptr_w = addr_size + 1;

    if (fifo_width < 2 || (fifo_width & (fifo_width - 1)) != 0 ||
        (32'd1 << addr_size) != fifo_width) begin : g_bad_params
        $error("fifo_rd_ctrl: fifo_width must be a power of two >= 2 equal to 2**addr_size");
    end

    logic [ptr_w-1:0] rbin;
    logic [ptr_w-1:0] rbin_next;
    logic [ptr_w-1:0] rgray_next;
    logic [ptr_w-1:0] wbin;
    logic             accept_c;

    gray_to_bin #(.addr_size(addr_size)) u_wptr_g2b (
        .gray (sync_wptr),
        .bin  (wbin)
    );

    // Status is computed against the post-increment pointer so a read that
    // drains the last entry flags empty in the same cycle it is acknowledged.
    always_comb begin
        accept_c   = rd_inc & ~empty;
        rbin_next  = rbin + ptr_w'(accept_c);
        rgray_next = ptr_w'(bin2gray(32'(rbin_next)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbin     <= '0;
            rd_ptr   <= '0;
            empty    <= 1'b1;
            rd_count <= '0;
            rd_ack   <= 1'b0;
        end else begin
            rbin     <= rbin_next;
            rd_ptr   <= rgray_next;
            empty    <= (rgray_next == sync_wptr);
            rd_count <= wbin - rbin_next;
            rd_ack   <= accept_c;
        end
    end

    assign rd_addr = rbin[addr_size-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed + randomized bench for fifo_rd_ctrl (fifo_width=8) against a count-based
// model: occupancy is total writes minus total reads, pointers follow from those counts.
module tb_fifo_rd_ctrl;

    logic       clk;
    logic       rst;
    logic       rd_inc;
    logic [3:0] sync_wptr;
    logic [2:0] rd_addr;
    logic [3:0] rd_ptr;
    logic       empty;
    logic [3:0] rd_count;
    logic       rd_ack;

    fifo_rd_ctrl #(.fifo_width(8), .addr_size(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_inc    (rd_inc),
        .sync_wptr (sync_wptr),
        .rd_addr   (rd_addr),
        .rd_ptr    (rd_ptr),
        .empty     (empty),
        .rd_count  (rd_count),
        .rd_ack    (rd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Reference model: total entries written (as seen through sync_wptr) and read.
    int   m_writes;
    int   m_reads;
    logic m_empty;
    logic m_ack;
    int   m_illegal;
    logic [3:0] prev_ptr;
    logic [3:0] ptr_tab [0:3];

    function automatic logic [3:0] gray(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    function automatic int occ();
        return (m_writes - m_reads) & 15;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_model();
        chk("rd_ack",   32'(rd_ack),   32'(m_ack));
        chk("empty",    32'(empty),    32'(m_empty));
        chk("rd_count", 32'(rd_count), 32'(occ()));
        chk("rd_addr",  32'(rd_addr),  32'(m_reads % 8));
        chk("rd_ptr",   32'(rd_ptr),   32'(gray(m_reads % 16)));
        chk("ptr_one_bit_step", 32'($countones(prev_ptr ^ rd_ptr) <= 1), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"},    32'(empty),    32'd1);
        chk({tag, "_rd_ptr"},   32'(rd_ptr),   32'd0);
        chk({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
        chk({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        chk({tag, "_rd_ack"},   32'(rd_ack),   32'd0);
    endtask

    task automatic model_reset();
        m_writes = 0;
        m_reads  = 0;
        m_empty  = 1'b1;
        m_ack    = 1'b0;
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge.
    task automatic step(input logic inc);
        logic acc;
        rd_inc    = inc;
        sync_wptr = gray(m_writes % 16);
        prev_ptr  = rd_ptr;
        @(posedge clk);
        acc     = inc && !m_empty;
        m_reads = m_reads + int'(acc);
        m_ack   = acc;
        m_empty = (occ() == 0);
        if (occ() > 8) begin
            m_illegal++;
            $display("note: sync_wptr implies illegal occupancy %0d", occ());
        end
        @(negedge clk);
        chk_model();
    endtask

    // Asynchronous reset applied between clock edges, checked before any edge.
    task automatic midclock_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_vals(tag);
        model_reset();
        sync_wptr = 4'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int   cyc;
        logic first;
        ptr_tab[0] = 4'b0001;
        ptr_tab[1] = 4'b0011;
        ptr_tab[2] = 4'b0010;
        ptr_tab[3] = 4'b0110;
        m_illegal = 0;
        rst       = 1'b0;
        rd_inc    = 1'b0;
        sync_wptr = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b1;
        prev_ptr = 4'd0;

        // Reads against an empty FIFO are ignored.
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            chk("empty_read_ack", 32'(rd_ack), 32'd0);
        end

        // Four entries written, then drained.
        m_writes = 4;
        step(1'b0);
        chk("w4_count", 32'(rd_count), 32'd4);
        chk("w4_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            chk("w4_addr", 32'(rd_addr), 32'(i + 1));
            chk("w4_ptr",  32'(rd_ptr),  32'(ptr_tab[i]));
            chk("w4_ack",  32'(rd_ack),  32'd1);
        end
        chk("w4_drained_empty", 32'(empty), 32'd1);
        chk("w4_drained_count", 32'(rd_count), 32'd0);

        midclock_reset("midrst");

        // Completely full FIFO, drained to wrap rd_addr.
        m_writes = 8;
        step(1'b0);
        chk("full_count", 32'(rd_count), 32'd8);
        chk("full_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1);
        chk("full_ptr",   32'(rd_ptr),  32'b1100);
        chk("full_addr",  32'(rd_addr), 32'd0);
        chk("full_empty_after", 32'(empty), 32'd1);

        // Reset while three entries are pending and a read is requested.
        m_writes = 11;
        step(1'b0);
        chk("pend3_count", 32'(rd_count), 32'd3);
        rd_inc = 1'b1;
        midclock_reset("pend_rst");

        // Random stream of 16 writes and 16 reads from a clean pointer.
        first = 1'b1;
        cyc   = 0;
        while (m_reads < 16 && cyc < 400) begin
            logic inc;
            if (m_writes < 16 && occ() < 8 && $urandom_range(0, 1) == 1) m_writes++;
            inc = ($urandom_range(0, 2) != 0);
            if (first && inc && !m_empty) begin
                chk("first_accept_addr", 32'(rd_addr), 32'd0);
                first = 1'b0;
            end
            step(inc);
            cyc++;
        end
        chk("stream_reads_done", 32'(m_reads), 32'd16);
        chk("stream_ptr_home",   32'(rd_ptr),  32'd0);
        chk("stream_empty",      32'(empty),   32'd1);

        // Illegal occupancy: reported by the bench, passed through unclamped by the DUT.
        midclock_reset("pre_illegal");
        m_writes = 12;
        step(1'b0);
        chk("illegal_count_unclamped", 32'(rd_count), 32'd12);
        chk("illegal_flagged", 32'(m_illegal > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
